axi_lite_mem_responder: RTL and testbench
=========================================

// Module: axi_lite_mem_responder
// PURPOSE
//  Memory-side end of the ar/r/aw/w/b handshake driven by the multicycle core's
//  write-back/memory stage. Single-ported word SRAM with programmable response
//  latency. Serves one transaction at a time and returns OKAY/SLVERR.
//  Sits between the core's mem_* initiator ports and the simulated memory.
// PARAMETERS
//  BASE_ADDR  32'h8000_0000  byte address of word 0
//  DEPTH      4096           number of 32-bit words (power of 2)
//  READ_LAT   2              cycles from AR accept to rvalid (0..15)
//  WRITE_LAT  2              cycles from last of AW/W accept to bvalid (0..15)
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous active-high reset
//  mem_arvalid  in   1   read address valid
//  mem_arready  out  1   read address accepted
//  mem_araddr   in   32  read byte address
//  mem_rvalid   out  1   read data valid
//  mem_rready   in   1   initiator accepts read data
//  mem_rdata    out  32  read data (full aligned word)
//  mem_rresp    out  2   00 OKAY, 10 SLVERR
//  mem_awvalid  in   1   write address valid
//  mem_awready  out  1   write address accepted
//  mem_awaddr   in   32  write byte address
//  mem_wvalid   in   1   write data valid
//  mem_wready   out  1   write data accepted
//  mem_wdata    in   32  write data
//  mem_wstrb    in   8   byte enables; bits [3:0] used, [7:4] ignored
//  mem_bvalid   out  1   write response valid
//  mem_bready   in   1   initiator accepts write response
//  mem_bresp    out  2   00 OKAY, 10 SLVERR
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state IDLE; all *ready, *valid low; rdata=0;
//   rresp=bresp=00; latency counter=0. Memory contents not cleared.
//  Readies are combinational from state+valids; valid/data/resp are registered.
//  Address decode: idx=(addr-BASE_ADDR)>>2; in range iff BASE_ADDR<=addr<
//   BASE_ADDR+4*DEPTH. addr[1:0] ignored. Out of range: rdata=0/SLVERR, write dropped/SLVERR.
//  States: IDLE, RD_WAIT, RD_RESP, WR_COLLECT, WR_WAIT, WR_RESP.
//  IDLE: arready=1. awready=wready=!arvalid (read wins on simultaneous arrival).
//   arvalid -> latch araddr, cnt=READ_LAT, go RD_WAIT.
//   else awvalid|wvalid -> latch whichever handshakes this cycle; both latched
//   -> WR_WAIT (cnt=WRITE_LAT) else WR_COLLECT.
//  WR_COLLECT: awready=!aw_got, wready=!w_got; arready=0. When both latched -> WR_WAIT.
//  RD_WAIT: cnt==0 -> read array, rvalid<=1, go RD_RESP; else cnt--.
//   READ_LAT=0 -> rvalid high the cycle after AR handshake (min latency 1).
//  RD_RESP: hold rvalid/rdata/rresp stable until rvalid&rready; then rvalid<=0,
//   go IDLE (next accept no earlier than following cycle).
//  WR_WAIT: cnt==0 -> byte-merge wdata per wstrb[3:0] into word, bvalid<=1,
//   go WR_RESP; else cnt--. wstrb[3:0]=0 -> no change, still OKAY.
//  WR_RESP: hold bvalid/bresp until bready; then bvalid<=0, go IDLE.
//  Array write occurs exactly once per write transaction, on WR_WAIT exit.
//  Reset mid-transaction: transaction abandoned, no array write if reset hits
//   before WR_WAIT exit; outputs return to reset values next cycle.
//  At most one outstanding transaction; no reordering, no bursts.
// TESTING
//  1 Write 0xDEADBEEF @0x8000_0010 wstrb=F, then read same -> bvalid 3 cycles
//    after AW/W accept (WRITE_LAT=2), bresp=00; rdata=0xDEADBEEF, rresp=00.
//  2 Write 0x11223344 wstrb=4'b0101 over 0xDEADBEEF -> read returns 0xDE22BE44.
//  3 arvalid+awvalid+wvalid same cycle -> arready=1, awready=wready=0; read done
//    first, write accepted only after rvalid&rready, returns to IDLE.
//  4 AW at cycle 0, W at cycle 3 -> WR_COLLECT holds; bvalid exactly
//    WRITE_LAT+1 cycles after W accept; wstrb[7:4]=F has no effect.
//  5 Read 0x0000_1000 and write 0x8000_4000 (DEPTH=4096) -> rresp=10 rdata=0;
//    bresp=10; subsequent in-range reads unchanged.
//  6 rready held low 5 cycles -> rvalid/rdata stable; rst asserted in WR_WAIT ->
//    bvalid never asserts, target word unchanged, arready=1 cycle after rst drops.

Source files
------------

// File: rtl/axi_lite_mem_responder.sv
// Memory-side AXI-lite style responder: single-ported word SRAM behind the
// ar/r/aw/w/b handshakes. It serves one transaction at a time, with a
// programmable response latency, and answers OKAY or SLVERR.
module axi_lite_mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 4096,
  parameter int          READ_LAT  = 2,
  parameter int          WRITE_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_arvalid,
  output logic        mem_arready,
  input  logic [31:0] mem_araddr,
  output logic        mem_rvalid,
  input  logic        mem_rready,
  output logic [31:0] mem_rdata,
  output logic [1:0]  mem_rresp,
  input  logic        mem_awvalid,
  output logic        mem_awready,
  input  logic [31:0] mem_awaddr,
  input  logic        mem_wvalid,
  output logic        mem_wready,
  input  logic [31:0] mem_wdata,
  input  logic [7:0]  mem_wstrb,
  output logic        mem_bvalid,
  input  logic        mem_bready,
  output logic [1:0]  mem_bresp
);

  localparam int         IDX_W  = $clog2(DEPTH);
  localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;
  localparam logic [3:0] RD_LAT = 4'(READ_LAT);
  localparam logic [3:0] WR_LAT = 4'(WRITE_LAT);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_RESP, WR_COLLECT, WR_WAIT, WR_RESP
  } state_t;

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_got, w_got;
  logic        rd_fire, wr_fire;
  logic        ar_hs, aw_hs, w_hs;
  logic [31:0] off;
  logic        in_range;
  logic [IDX_W-1:0] idx;
  logic [31:0] mem [DEPTH];

  // Upper strobe lanes belong to a 64-bit bus view and are not meaningful here.
  logic unused_wstrb_hi;
  assign unused_wstrb_hi = ^mem_wstrb[7:4];

  // Decode the latched address; addr[1:0] falls away with the word index.
  assign off      = addr_q - BASE_ADDR;
  assign in_range = (addr_q >= BASE_ADDR) && ({1'b0, off} < SPAN);
  assign idx      = off[IDX_W+1:2];

  assign ar_hs = mem_arvalid & mem_arready;
  assign aw_hs = mem_awvalid & mem_awready;
  assign w_hs  = mem_wvalid  & mem_wready;

  // Next-state, latency counter and combinational readies.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    mem_arready = 1'b0;
    mem_awready = 1'b0;
    mem_wready  = 1'b0;
    rd_fire     = 1'b0;
    wr_fire     = 1'b0;
    case (state)
      IDLE: begin
        mem_arready = 1'b1;
        mem_awready = !mem_arvalid;
        mem_wready  = !mem_arvalid;
        if (mem_arvalid) begin
          state_d = RD_WAIT;
          cnt_d   = RD_LAT;
        end else if (mem_awvalid && mem_wvalid) begin
          state_d = WR_WAIT;
          cnt_d   = WR_LAT;
        end else if (mem_awvalid || mem_wvalid) begin
          state_d = WR_COLLECT;
        end
      end
      WR_COLLECT: begin
        mem_awready = !aw_got;
        mem_wready  = !w_got;
        if ((aw_got || mem_awvalid) && (w_got || mem_wvalid)) begin
          state_d = WR_WAIT;
          cnt_d   = WR_LAT;
        end
      end
      RD_WAIT: begin
        if (cnt == 4'd0) begin
          rd_fire = 1'b1;
          state_d = RD_RESP;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      RD_RESP: if (mem_rready) state_d = IDLE;
      WR_WAIT: begin
        if (cnt == 4'd0) begin
          wr_fire = 1'b1;
          state_d = WR_RESP;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      WR_RESP: if (mem_bready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Nothing is accepted while reset is held.
    if (rst) begin
      mem_arready = 1'b0;
      mem_awready = 1'b0;
      mem_wready  = 1'b0;
    end
  end

  // State, captured request fields and registered response channels.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'd0;
      aw_got     <= 1'b0;
      w_got      <= 1'b0;
      mem_rvalid <= 1'b0;
      mem_rdata  <= 32'd0;
      mem_rresp  <= OKAY;
      mem_bvalid <= 1'b0;
      mem_bresp  <= OKAY;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (ar_hs) addr_q <= mem_araddr;
      if (aw_hs) addr_q <= mem_awaddr;
      if (w_hs) begin
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wstrb[3:0];
      end
      aw_got <= (state == IDLE) ? aw_hs : (aw_got | aw_hs);
      w_got  <= (state == IDLE) ? w_hs  : (w_got  | w_hs);
      if (rd_fire) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= in_range ? mem[idx] : 32'd0;
        mem_rresp  <= in_range ? OKAY : SLVERR;
      end else if (mem_rvalid && mem_rready) begin
        mem_rvalid <= 1'b0;
      end
      if (wr_fire) begin
        mem_bvalid <= 1'b1;
        mem_bresp  <= in_range ? OKAY : SLVERR;
      end else if (mem_bvalid && mem_bready) begin
        mem_bvalid <= 1'b0;
      end
    end
  end

  // Byte-merged array write, exactly once when the write latency expires.
  // NOTE: the array has no reset; contents survive rst, only the write is
  // suppressed while rst is asserted.
  always_ff @(posedge clk) begin
    if (wr_fire && in_range && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Directed self-checking bench for axi_lite_mem_responder (default parameters).
module tb_axi_lite_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_arvalid = 1'b0, mem_arready;
  logic [31:0] mem_araddr = 32'd0;
  logic        mem_rvalid, mem_rready = 1'b0;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        mem_awvalid = 1'b0, mem_awready;
  logic [31:0] mem_awaddr = 32'd0;
  logic        mem_wvalid = 1'b0, mem_wready;
  logic [31:0] mem_wdata = 32'd0;
  logic [7:0]  mem_wstrb = 8'd0;
  logic        mem_bvalid, mem_bready = 1'b0;
  logic [1:0]  mem_bresp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_lite_mem_responder dut (
    .clk(clk), .rst(rst),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
    .mem_rresp(mem_rresp),
    .mem_awvalid(mem_awvalid), .mem_awready(mem_awready), .mem_awaddr(mem_awaddr),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_bvalid(mem_bvalid), .mem_bready(mem_bready), .mem_bresp(mem_bresp)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Called at a negedge just after the accepting edge; lat counts edges to bvalid.
  task automatic wait_b(output int lat, output logic [1:0] resp);
    lat = 0;
    while (!mem_bvalid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 50) check("b_timeout", 32'(lat), 32'd0);
    resp = mem_bresp;
    mem_bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_bready = 1'b0;
    check("b_drop", 32'(mem_bvalid), 32'd0);
  endtask

  task automatic wait_r(output int lat, output logic [31:0] d, output logic [1:0] resp);
    lat = 0;
    while (!mem_rvalid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 50) check("r_timeout", 32'(lat), 32'd0);
    d    = mem_rdata;
    resp = mem_rresp;
    mem_rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_rready = 1'b0;
    check("r_drop", 32'(mem_rvalid), 32'd0);
  endtask

  // Start at a negedge; returns at a negedge.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s,
                          output logic [1:0] resp, output int lat);
    int n = 0;
    mem_awvalid = 1'b1; mem_awaddr = a;
    mem_wvalid  = 1'b1; mem_wdata  = d; mem_wstrb = s;
    #1;
    while (!(mem_awready && mem_wready) && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) check("aw_w_timeout", 32'(n), 32'd0);
    @(posedge clk);
    @(negedge clk);
    mem_awvalid = 1'b0; mem_wvalid = 1'b0;
    wait_b(lat, resp);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                         output logic [1:0] resp, output int lat);
    int n = 0;
    mem_arvalid = 1'b1; mem_araddr = a;
    #1;
    while (!mem_arready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) check("ar_timeout", 32'(n), 32'd0);
    @(posedge clk);
    @(negedge clk);
    mem_arvalid = 1'b0;
    wait_r(lat, d, resp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  resp;
    int          lat;
    int          seen;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_arready", 32'(mem_arready), 32'd0);
    check("rst_rvalid",  32'(mem_rvalid),  32'd0);
    check("rst_bvalid",  32'(mem_bvalid),  32'd0);
    check("rst_rdata",   mem_rdata,        32'd0);
    check("rst_resp",    32'({mem_rresp, mem_bresp}), 32'd0);
    rst = 1'b0;
    #1;
    check("idle_arready", 32'(mem_arready), 32'd1);
    @(negedge clk);

    // 1: full write then read back, latency WRITE_LAT+1 / READ_LAT+1
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, resp, lat);
    check("t1_blat",  32'(lat),  32'd3);
    check("t1_bresp", 32'(resp), 32'd0);
    do_read(32'h8000_0010, d, resp, lat);
    check("t1_rlat",  32'(lat),  32'd3);
    check("t1_rdata", d,         32'hDEAD_BEEF);
    check("t1_rresp", 32'(resp), 32'd0);

    // 2: partial strobe merge (byte lanes 0 and 2)
    do_write(32'h8000_0012, 32'h1122_3344, 8'h05, resp, lat);
    do_read(32'h8000_0010, d, resp, lat);
    check("t2_merge", d, 32'hDE22_BE44);

    // 3: simultaneous arrival, read wins
    mem_arvalid = 1'b1; mem_araddr = 32'h8000_0010;
    mem_awvalid = 1'b1; mem_awaddr = 32'h8000_0030;
    mem_wvalid  = 1'b1; mem_wdata  = 32'h0102_0304; mem_wstrb = 8'h0F;
    #1;
    check("t3_arready", 32'(mem_arready), 32'd1);
    check("t3_awready", 32'({mem_awready, mem_wready}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    mem_arvalid = 1'b0;
    #1;
    check("t3_aw_blocked", 32'({mem_awready, mem_wready}), 32'd0);
    while (!mem_rvalid && lat < 100) begin @(negedge clk); lat++; end
    #1;
    check("t3_aw_blocked_resp", 32'({mem_awready, mem_wready}), 32'd0);
    wait_r(lat, d, resp);
    check("t3_rdata", d, 32'hDE22_BE44);
    #1;
    check("t3_aw_open", 32'({mem_awready, mem_wready}), 32'd3);
    @(posedge clk);
    @(negedge clk);
    mem_awvalid = 1'b0; mem_wvalid = 1'b0;
    wait_b(lat, resp);
    check("t3_blat", 32'(lat), 32'd3);
    do_read(32'h8000_0030, d, resp, lat);
    check("t3_wdata", d, 32'h0102_0304);

    // 4: AW first, W three cycles later; upper strobe lanes ignored
    do_write(32'h8000_0020, 32'hAABB_CCDD, 8'h0F, resp, lat);
    mem_awvalid = 1'b1; mem_awaddr = 32'h8000_0020;
    #1;
    check("t4_awready", 32'(mem_awready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    mem_awvalid = 1'b0;
    #1;
    check("t4_collect", 32'({mem_awready, mem_wready}), 32'd1);
    repeat (2) @(negedge clk);
    check("t4_no_b", 32'(mem_bvalid), 32'd0);
    mem_wvalid = 1'b1; mem_wdata = 32'h5566_7788; mem_wstrb = 8'hF1;
    #1;
    check("t4_wready", 32'(mem_wready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    mem_wvalid = 1'b0;
    wait_b(lat, resp);
    check("t4_blat", 32'(lat), 32'd3);
    do_read(32'h8000_0020, d, resp, lat);
    check("t4_merge", d, 32'hAABB_CC88);

    // 5: out-of-range accesses and the top in-range word
    do_write(32'h8000_0000, 32'h0BAD_CAFE, 8'h0F, resp, lat);
    do_write(32'h8000_3FFC, 32'h1234_5678, 8'h0F, resp, lat);
    check("t5_top_bresp", 32'(resp), 32'd0);
    do_read(32'h0000_1000, d, resp, lat);
    check("t5_oor_rresp", 32'(resp), 32'd2);
    check("t5_oor_rdata", d, 32'd0);
    do_write(32'h8000_4000, 32'hFFFF_FFFF, 8'h0F, resp, lat);
    check("t5_oor_bresp", 32'(resp), 32'd2);
    do_read(32'h8000_0000, d, resp, lat);
    check("t5_word0", d, 32'h0BAD_CAFE);
    do_read(32'h8000_3FFC, d, resp, lat);
    check("t5_top", d, 32'h1234_5678);
    do_read(32'h8000_0010, d, resp, lat);
    check("t5_word4", d, 32'hDE22_BE44);

    // 6a: rready held low, response held stable
    mem_arvalid = 1'b1; mem_araddr = 32'h8000_0030;
    @(posedge clk);
    @(negedge clk);
    mem_arvalid = 1'b0;
    lat = 0;
    while (!mem_rvalid && lat < 50) begin @(negedge clk); lat++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6_hold_valid", 32'(mem_rvalid), 32'd1);
      check("t6_hold_data",  mem_rdata,       32'h0102_0304);
    end
    wait_r(lat, d, resp);
    check("t6_hold_final", d, 32'h0102_0304);

    // 6b: reset during WR_WAIT abandons the write
    mem_awvalid = 1'b1; mem_awaddr = 32'h8000_0010;
    mem_wvalid  = 1'b1; mem_wdata  = 32'hCAFE_F00D; mem_wstrb = 8'h0F;
    @(posedge clk);
    @(negedge clk);
    mem_awvalid = 1'b0; mem_wvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_rst_arready", 32'(mem_arready), 32'd1);
    check("t6_rst_bvalid",  32'(mem_bvalid),  32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_bvalid) seen++;
    end
    check("t6_no_bvalid", 32'(seen), 32'd0);
    do_read(32'h8000_0010, d, resp, lat);
    check("t6_word_kept", d, 32'hDE22_BE44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
